// File: rtl/reaction_timebase.sv
// Timing datapath for the reaction-timer game: ms prescaler, LFSR-randomised wait,
// fixed 5 s wait, BCD reaction counter with late flag, and result/best-time capture.
module reaction_timebase #(
    parameter int TICK_DIV        = 100000,
    parameter int RWAIT_MIN_MS    = 1000,
    parameter int RWAIT_RAND_BITS = 12,
    parameter int WAIT5_MS        = 5000,
    parameter int LATE_MS         = 1000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start_rwait,
    input  logic        start_wait5,
    input  logic        time_clr,
    input  logic        time_en,
    input  logic        rs_en,
    output logic        rwait_done,
    output logic        wait5_done,
    output logic        time_late,
    output logic [15:0] time_bcd,
    output logic [15:0] result_bcd,
    output logic        result_valid,
    output logic [15:0] best_bcd,
    output logic        new_best
);

    localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [11:0] SEED     = 12'hACE;
    localparam logic [13:0] BCD_MAX  = 14'd9999;

    // One BCD increment with digit carries; holds at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [PW-1:0] presc;
    logic          tick;
    logic [11:0]   lfsr;
    logic          lfsr_fb;

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign lfsr_fb = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (RESET || tick) presc <= '0;
        else               presc <= presc + PW'(1);
    end

    // A stuck all-zero state is recovered by reloading the seed.
    always_ff @(posedge clk) begin
        if (RESET || lfsr == 12'd0) lfsr <= SEED;
        else                        lfsr <= {lfsr[10:0], lfsr_fb};
    end

    logic        rwait_q;
    logic [13:0] rwait_ms;
    logic [13:0] rwait_tgt;

    always_ff @(posedge clk) begin
        if (RESET) begin
            rwait_q    <= 1'b0;
            rwait_ms   <= '0;
            rwait_tgt  <= '0;
            rwait_done <= 1'b0;
        end else begin
            rwait_q <= start_rwait;
            if (!start_rwait) begin
                rwait_ms   <= '0;
                rwait_done <= 1'b0;
            end else if (!rwait_q) begin
                rwait_tgt  <= 14'(RWAIT_MIN_MS) + 14'(lfsr[RWAIT_RAND_BITS-1:0]);
                rwait_ms   <= '0;
                rwait_done <= 1'b0;
            end else if (!rwait_done && tick) begin
                rwait_ms <= rwait_ms + 14'd1;
                if (rwait_ms + 14'd1 == rwait_tgt) rwait_done <= 1'b1;
            end
        end
    end

    logic        wait5_q;
    logic [13:0] wait5_ms;

    always_ff @(posedge clk) begin
        if (RESET) begin
            wait5_q    <= 1'b0;
            wait5_ms   <= '0;
            wait5_done <= 1'b0;
        end else begin
            wait5_q <= start_wait5;
            if (!start_wait5 || !wait5_q) begin
                wait5_ms   <= '0;
                wait5_done <= 1'b0;
            end else if (!wait5_done && tick) begin
                wait5_ms <= wait5_ms + 14'd1;
                if (wait5_ms + 14'd1 == 14'(WAIT5_MS)) wait5_done <= 1'b1;
            end
        end
    end

    // Binary count drives the late compare; the BCD copy feeds the display.
    logic [13:0] bin;
    logic [13:0] bin_nxt;
    logic [15:0] bcd_nxt;

    always_comb begin
        bin_nxt = bin;
        bcd_nxt = time_bcd;
        if (time_clr) begin
            bin_nxt = '0;
            bcd_nxt = '0;
        end else if (time_en && tick && bin != BCD_MAX) begin
            bin_nxt = bin + 14'd1;
            bcd_nxt = bcd_inc_sat(time_bcd);
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            bin       <= '0;
            time_bcd  <= '0;
            time_late <= 1'b0;
        end else begin
            bin      <= bin_nxt;
            time_bcd <= bcd_nxt;
            if (time_clr)                          time_late <= 1'b0;
            else if (bin_nxt >= 14'(LATE_MS))      time_late <= 1'b1;
        end
    end

    // BCD digits order the same way as plain unsigned values, so a direct compare works.
    logic rs_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            rs_q         <= 1'b0;
            result_bcd   <= '0;
            result_valid <= 1'b0;
            best_bcd     <= 16'h9999;
            new_best     <= 1'b0;
        end else begin
            rs_q     <= rs_en;
            new_best <= 1'b0;
            if (rs_en && !rs_q) begin
                result_bcd   <= time_bcd;
                result_valid <= 1'b1;
                if (time_bcd < best_bcd) begin
                    best_bcd <= time_bcd;
                    new_best <= 1'b1;
                end
            end
        end
    end

endmodule
